mips_mc_controller: RTL

- Multi-cycle control unit that drives the control ports of the MIPS datapath: pcsrc1..3, rdst1..3, regwrite, alusrc, memread, memwrite, memtoreg, branch, rfsrc, ld and aluop.
- Consumes the datapath's opcode, func and zero.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and pulses ld once per retired instruction.
- Provides a mem_ready handshake toward a slow data memory.

---
 rtl/mips_mc_controller.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a mem_ready wait and a sticky timeout flag.
// Optional retire counter output `retired` is built when MIPS_RETIRE_CNT_EN is defined.
module mips_mc_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcsrc1,
  output logic       pcsrc2,
  output logic       pcsrc3,
  output logic       rdst1,
  output logic       rdst2,
  output logic       rdst3,
  output logic       regwrite,
  output logic       memread,
  output logic       memwrite,
  output logic       ld,
  output logic       alusrc,
  output logic       memtoreg,
  output logic       branch,
  output logic       rfsrc,
  output logic [2:0] aluop,
  output logic       mem_err,
  output logic [2:0] dbg_state_o
`ifdef MIPS_RETIRE_CNT_EN
  ,
  output logic [31:0] retired
`endif
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    K_ALU, K_LW, K_SW, K_BEQ, K_SHORT, K_JAL
  } kind_t;

  state_t        state_q;
  logic [5:0]    ir_op_q, ir_fn_q;
  logic [CW-1:0] wait_q;
  logic          mem_err_q;

  kind_t      kind;
  logic       d_pcsrc2, d_pcsrc3, d_rdst1, d_rdst3, d_alusrc, d_memtoreg, d_branch, d_rfsrc;
  logic [2:0] d_aluop;
  logic       active, timeout, mem_done;

  // Instruction class and static selects come only from the latched instruction.
  always_comb begin
    kind       = K_SHORT;
    d_pcsrc2   = 1'b1;
    d_pcsrc3   = 1'b1;
    d_rdst1    = 1'b0;
    d_rdst3    = 1'b0;
    d_alusrc   = 1'b0;
    d_memtoreg = 1'b0;
    d_branch   = 1'b0;
    d_rfsrc    = 1'b0;
    d_aluop    = 3'b000;
    case (ir_op_q)
      6'b000000: begin
        case (ir_fn_q)
          6'b100000: begin kind = K_ALU; d_aluop = 3'b000; end
          6'b100010: begin kind = K_ALU; d_aluop = 3'b001; end
          6'b100100: begin kind = K_ALU; d_aluop = 3'b010; end
          6'b100101: begin kind = K_ALU; d_aluop = 3'b011; end
          6'b101010: begin kind = K_ALU; d_aluop = 3'b100; end
          6'b001000: d_pcsrc3 = 1'b0;
          default: ;
        endcase
        if (kind == K_ALU) begin
          d_rdst1    = 1'b1;
          d_memtoreg = 1'b1;
          d_rfsrc    = 1'b1;
        end
      end
      6'b001000, 6'b001010: begin
        kind       = K_ALU;
        d_alusrc   = 1'b1;
        d_memtoreg = 1'b1;
        d_rfsrc    = 1'b1;
        d_aluop    = ir_op_q[1] ? 3'b100 : 3'b000;
      end
      6'b100011, 6'b101011: begin
        kind     = ir_op_q[3] ? K_SW : K_LW;
        d_alusrc = 1'b1;
        d_rfsrc  = 1'b1;
      end
      6'b000100: begin kind = K_BEQ; d_branch = 1'b1; d_aluop = 3'b001; end
      6'b000010: d_pcsrc2 = 1'b0;
      6'b000011: begin kind = K_JAL; d_pcsrc2 = 1'b0; d_rdst3 = 1'b1; end
      default: ;
    endcase
  end

  // Selects are quiet in FETCH so nothing but zeros is visible coming out of reset.
  assign active   = (state_q != S_FETCH);
  assign timeout  = (state_q == S_MEM) && !mem_ready && (wait_q == CW'(MEM_TIMEOUT - 1));
  assign mem_done = mem_ready | timeout;

  assign ld = (state_q == S_WB)
            | ((state_q == S_DECODE) && (kind == K_SHORT))
            | ((state_q == S_EXEC) && (kind == K_BEQ))
            | ((state_q == S_MEM) && (kind == K_SW) && mem_done);

  assign regwrite = (state_q == S_WB);
  assign memread  = (kind == K_LW) && ((state_q == S_MEM) || (state_q == S_WB));
  assign memwrite = (kind == K_SW) && (state_q == S_MEM);
  assign pcsrc2   = active & d_pcsrc2;
  assign pcsrc3   = active & d_pcsrc3;
  assign rdst1    = active & d_rdst1;
  assign rdst2    = 1'b0;
  assign rdst3    = active & d_rdst3;
  assign alusrc   = active & d_alusrc;
  assign memtoreg = active & d_memtoreg;
  assign branch   = active & d_branch;
  assign rfsrc    = active & d_rfsrc;
  assign aluop    = active ? d_aluop : 3'b000;
  assign pcsrc1   = branch & zero & ld;
  assign mem_err  = mem_err_q | timeout;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      ir_op_q   <= 6'd0;
      ir_fn_q   <= 6'd0;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          ir_op_q <= opcode;
          ir_fn_q <= func;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (kind == K_SHORT)    state_q <= S_FETCH;
          else if (kind == K_JAL) state_q <= S_WB;
          else                    state_q <= S_EXEC;
        end
        S_EXEC: begin
          wait_q <= '0;
          if (kind == K_BEQ)                        state_q <= S_FETCH;
          else if ((kind == K_LW) || (kind == K_SW)) state_q <= S_MEM;
          else                                      state_q <= S_WB;
        end
        S_MEM: begin
          if (mem_done) begin
            state_q <= (kind == K_LW) ? S_WB : S_FETCH;
            if (timeout) mem_err_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

`ifdef MIPS_RETIRE_CNT_EN
  logic [31:0] retired_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    retired_q <= 32'd0;
    else if (ld) retired_q <= retired_q + 32'd1;
  end
  assign retired = retired_q;
`endif

endmodule
